// File: rtl/alu_pwr_pkg.sv
// Shared types for the ALU power sequencer: state encoding and the
// power-switch / isolation / local-reset vector each state drives.
package alu_pwr_pkg;

    typedef enum logic [2:0] {
        ST_OFF     = 3'd0,
        ST_PWR_UP  = 3'd1,
        ST_RST_REL = 3'd2,
        ST_ON      = 3'd3,
        ST_DRAIN   = 3'd4,
        ST_ISO_SET = 3'd5
    } pwr_state_e;

    typedef struct packed {
        logic pwr_en;
        logic iso_en;
        logic rst_n;
    } pwr_vec_t;

    localparam pwr_vec_t VEC_OFF     = '{pwr_en: 1'b0, iso_en: 1'b1, rst_n: 1'b0};
    localparam pwr_vec_t VEC_PWR_UP  = '{pwr_en: 1'b1, iso_en: 1'b1, rst_n: 1'b0};
    localparam pwr_vec_t VEC_RST_REL = '{pwr_en: 1'b1, iso_en: 1'b1, rst_n: 1'b1};
    localparam pwr_vec_t VEC_ON      = '{pwr_en: 1'b1, iso_en: 1'b0, rst_n: 1'b1};
    localparam pwr_vec_t VEC_DRAIN   = '{pwr_en: 1'b1, iso_en: 1'b0, rst_n: 1'b1};
    localparam pwr_vec_t VEC_ISO_SET = '{pwr_en: 1'b1, iso_en: 1'b1, rst_n: 1'b1};

    function automatic pwr_vec_t state_vec(input pwr_state_e s);
        case (s)
            ST_PWR_UP:  return VEC_PWR_UP;
            ST_RST_REL: return VEC_RST_REL;
            ST_ON:      return VEC_ON;
            ST_DRAIN:   return VEC_DRAIN;
            ST_ISO_SET: return VEC_ISO_SET;
            default:    return VEC_OFF;
        endcase
    endfunction

endpackage

// File: rtl/alu_pwr_seq_if.sv
// Host/ALU-side signal bundle of the power sequencer; the host (master)
// drives requests and busy, the sequencer (slave) drives power controls.
interface alu_pwr_seq_if;
    logic       pwr_req;
    logic       start_in;
    logic       alu_busy;
    logic       alu_start;
    logic       start_stall;
    logic       alu_pwr_en;
    logic       iso_en;
    logic       alu_rst_n;
    logic       pwr_on;
    logic [2:0] state_obs;

    modport master (
        output pwr_req, start_in, alu_busy,
        input  alu_start, start_stall, alu_pwr_en, iso_en, alu_rst_n, pwr_on, state_obs
    );

    modport slave (
        input  pwr_req, start_in, alu_busy,
        output alu_start, start_stall, alu_pwr_en, iso_en, alu_rst_n, pwr_on, state_obs
    );
endinterface

// File: rtl/alu_pwr_timer.sv
// Loadable saturating down-counter; done flags the last cycle of a wait of
// val cycles started by load.
module alu_pwr_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] val,
    output logic             done
);
    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= val;
        end else if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

    // A wait of N cycles ends on the edge where the counter still reads 1.
    assign done = (cnt_reg <= CNT_W'(1));

endmodule

// File: rtl/alu_pwr_seq.sv
// ALU power-domain sequencer: orders power switch, isolation and local reset,
// and gates host starts. Optional idle auto-sleep: ALU_PWR_IDLE_SLEEP_EN.
module alu_pwr_seq
    import alu_pwr_pkg::*;
#(
    parameter int PWR_UP_CYC    = 4,
    parameter int ISO_SETUP_CYC = 2,
    parameter int IDLE_CYC      = 16,
    parameter int CNT_W         = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_pwr_seq_if.slave bus
);
    if (PWR_UP_CYC < 1 || ISO_SETUP_CYC < 1 || IDLE_CYC < 1 ||
        PWR_UP_CYC >= (1 << CNT_W) || ISO_SETUP_CYC >= (1 << CNT_W) ||
        IDLE_CYC >= (1 << CNT_W)) begin : g_param_check
        $error("alu_pwr_seq: cycle parameters must be >= 1 and fit in CNT_W bits");
    end

    pwr_state_e       state_reg, state_next;
    pwr_vec_t         out_reg;
    logic             pwr_on_reg;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_done;
    logic             wake;

`ifdef ALU_PWR_IDLE_SLEEP_EN
    logic             sleep_reg, sleep_next;
    logic [CNT_W-1:0] idle_reg, idle_next;
`endif

    alu_pwr_timer #(.CNT_W(CNT_W)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (tmr_load),
        .val   (tmr_val),
        .done  (tmr_done)
    );

`ifdef ALU_PWR_IDLE_SLEEP_EN
    // After an auto-sleep only a host start may bring the domain back.
    assign wake = bus.pwr_req & (~sleep_reg | bus.start_in);
`else
    assign wake = bus.pwr_req;
`endif

    always_comb begin
        state_next = state_reg;
        tmr_load   = 1'b0;
        tmr_val    = '0;
`ifdef ALU_PWR_IDLE_SLEEP_EN
        sleep_next = sleep_reg;
        idle_next  = '0;
`endif
        case (state_reg)
            ST_OFF: begin
                if (wake) begin
                    state_next = ST_PWR_UP;
                    tmr_load   = 1'b1;
                    tmr_val    = CNT_W'(PWR_UP_CYC);
`ifdef ALU_PWR_IDLE_SLEEP_EN
                    sleep_next = 1'b0;
`endif
                end
            end
            ST_PWR_UP: begin
                if (tmr_done) state_next = ST_RST_REL;
            end
            ST_RST_REL: state_next = ST_ON;
            ST_ON: begin
                if (!bus.pwr_req) begin
                    state_next = ST_DRAIN;
                end
`ifdef ALU_PWR_IDLE_SLEEP_EN
                else if (bus.start_in || bus.alu_busy) begin
                    idle_next = '0;
                end else if (idle_reg == CNT_W'(IDLE_CYC - 1)) begin
                    state_next = ST_DRAIN;
                    sleep_next = 1'b1;
                end else begin
                    idle_next = idle_reg + 1'b1;
                end
`endif
            end
            ST_DRAIN: begin
                // Isolation is still off here, so a renewed request may abort.
                if (wake) begin
                    state_next = ST_ON;
`ifdef ALU_PWR_IDLE_SLEEP_EN
                    sleep_next = 1'b0;
`endif
                end else if (!bus.alu_busy) begin
                    state_next = ST_ISO_SET;
                    tmr_load   = 1'b1;
                    tmr_val    = CNT_W'(ISO_SETUP_CYC);
                end
            end
            ST_ISO_SET: begin
                if (tmr_done) state_next = ST_OFF;
            end
            default: state_next = ST_OFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= ST_OFF;
            out_reg    <= VEC_OFF;
            pwr_on_reg <= 1'b0;
`ifdef ALU_PWR_IDLE_SLEEP_EN
            sleep_reg  <= 1'b0;
            idle_reg   <= '0;
`endif
        end else begin
            state_reg  <= state_next;
            // Pin outputs follow the state one edge later, so isolation is
            // always settled around every power-switch transition.
            out_reg    <= state_vec(state_reg);
            pwr_on_reg <= (state_reg == ST_ON);
`ifdef ALU_PWR_IDLE_SLEEP_EN
            sleep_reg  <= sleep_next;
            idle_reg   <= idle_next;
`endif
        end
    end

    assign bus.alu_start   = bus.start_in & (state_reg == ST_ON);
    assign bus.start_stall = bus.start_in & (state_reg != ST_ON);
    assign bus.alu_pwr_en  = out_reg.pwr_en;
    assign bus.iso_en      = out_reg.iso_en;
    assign bus.alu_rst_n   = out_reg.rst_n;
    assign bus.pwr_on      = pwr_on_reg;
    assign bus.state_obs   = state_reg;

endmodule
